// File: rtl/override_auth_arbiter.sv
// ----------------------------------------------------------------------------
// override_auth_arbiter
//
// Purpose:
//   Arbitrates analog override requests from N_REQ requesters. A lock request
//   always beats a flush request; within a class the winner is picked
//   round-robin, starting one past the last grant. The accepted token is
//   checked against a loaded 16-bit key for one cycle. On a match the
//   selected override plus the auth-valid flag are held for HOLD_CYCLES.
//   On a mismatch auth_fail pulses and the failure counter advances. Either
//   outcome is followed by COOLDOWN_CYCLES idle cycles. MAX_FAILS consecutive
//   failures raise a sticky lockout that only a key write or reset clears.
//
// Optional feature:
//   OVERRIDE_AUDIT_LOG_EN - when defined, audit_grant_cnt / audit_fail_cnt
//   count passed / failed checks (saturating at 255, cleared only by reset).
//   When undefined both ports read 0 and no counter flops exist.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid[N_REQ]            per-requester request valid
//   req_kind[N_REQ]             1 = lock, 0 = flush
//   req_token[16*N_REQ]         requester i token at [16i+15:16i]
//   req_ready[N_REQ]            combinational one-hot accept strobe (IDLE only)
//   key_wr_en, key_wr_data      load authentication key
//   analog_lock_override        registered override to the FSM overlay
//   analog_flush_override       registered override to the FSM overlay
//   override_authentication_valid_in  registered auth-valid to the overlay
//   grant_id[3]                 index of last accepted requester
//   auth_fail                   one-cycle pulse, first cycle after a failed check
//   lockout                     sticky lockout flag
//   audit_grant_cnt[8]          passed-check counter (optional)
//   audit_fail_cnt[8]           failed-check counter (optional)
// ----------------------------------------------------------------------------
module override_auth_arbiter #(
  parameter int N_REQ           = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int MAX_FAILS       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_kind,
  input  logic [16*N_REQ-1:0]  req_token,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 key_wr_en,
  input  logic [15:0]          key_wr_data,
  output logic                 analog_lock_override,
  output logic                 analog_flush_override,
  output logic                 override_authentication_valid_in,
  output logic [2:0]           grant_id,
  output logic                 auth_fail,
  output logic                 lockout,
  output logic [7:0]           audit_grant_cnt,
  output logic [7:0]           audit_fail_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_ASSERT   = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_key;
  logic        r_key_loaded;
  logic [3:0]  r_fail_cnt;
  logic        r_lockout;
  logic [2:0]  r_ptr;
  logic [2:0]  r_grant_id;
  logic        r_kind;
  logic [15:0] r_token;
  logic [15:0] r_cnt;
  logic        r_lock_ovr;
  logic        r_flush_ovr;
  logic        r_auth_valid;
  logic        r_auth_fail;

  state_t      w_state_next;
  logic [15:0] w_key_next;
  logic        w_key_loaded_next;
  logic [3:0]  w_fail_cnt_next;
  logic        w_lockout_next;
  logic [2:0]  w_ptr_next;
  logic [2:0]  w_grant_id_next;
  logic        w_kind_next;
  logic [15:0] w_token_next;
  logic [15:0] w_cnt_next;
  logic        w_lock_ovr_next;
  logic        w_flush_ovr_next;
  logic        w_auth_valid_next;
  logic        w_auth_fail_next;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0]   w_lock_req;
  logic [N_REQ-1:0]   w_flush_req;
  logic [N_REQ-1:0]   w_cand;
  logic [2*N_REQ-1:0] w_cand2;
  logic [N_REQ-1:0]   w_rot;
  logic [2:0]         w_off;
  logic [3:0]         w_sum;
  logic [2:0]         w_win_id;
  logic [3:0]         w_win_inc;
  logic [2:0]         w_ptr_after;
  logic               w_grant_ok;
  logic               w_transfer;
  logic [15:0]        w_tok_sel;
  logic               w_kind_sel;
  logic               w_tok_match;
  logic [3:0]         w_fail_inc;

  assign w_lock_req  = req_valid & req_kind;
  assign w_flush_req = req_valid & ~req_kind;
  // Only the higher-priority class competes when any lock is pending.
  assign w_cand      = (|w_lock_req) ? w_lock_req : w_flush_req;
  // Rotating the doubled vector right by the pointer puts the round-robin
  // start position at bit 0, so the lowest set bit is the winner's offset.
  assign w_cand2     = {w_cand, w_cand};
  assign w_rot       = N_REQ'(w_cand2 >> r_ptr);

  always_comb begin
    w_off = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 3'(k);
      end
    end
  end

  assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win_id    = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : 3'(w_sum);
  assign w_win_inc   = {1'b0, w_win_id} + 4'd1;
  assign w_ptr_after = (w_win_inc == 4'(N_REQ)) ? 3'd0 : 3'(w_win_inc);

  assign w_grant_ok  = (r_state == S_IDLE) && r_key_loaded && !r_lockout && (|w_cand);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_grant_ok && (w_win_id == 3'(gi));
    end
  endgenerate

  // req_ready is only ever set on a valid requester, so any strobe is a transfer.
  assign w_transfer = |req_ready;

  always_comb begin
    w_tok_sel  = 16'd0;
    w_kind_sel = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win_id == 3'(k)) begin
        w_tok_sel  = req_token[16*k +: 16];
        w_kind_sel = req_kind[k];
      end
    end
  end

  // r_key still holds the pre-write value during a coinciding key write.
  assign w_tok_match = (r_token == r_key);
  assign w_fail_inc  = (r_fail_cnt >= 4'(MAX_FAILS)) ? r_fail_cnt : r_fail_cnt + 4'd1;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_key_next        = r_key;
    w_key_loaded_next = r_key_loaded;
    w_fail_cnt_next   = r_fail_cnt;
    w_lockout_next    = r_lockout;
    w_ptr_next        = r_ptr;
    w_grant_id_next   = r_grant_id;
    w_kind_next       = r_kind;
    w_token_next      = r_token;
    w_cnt_next        = r_cnt;
    w_lock_ovr_next   = r_lock_ovr;
    w_flush_ovr_next  = r_flush_ovr;
    w_auth_valid_next = r_auth_valid;
    w_auth_fail_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_transfer) begin
          w_kind_next     = w_kind_sel;
          w_token_next    = w_tok_sel;
          w_grant_id_next = w_win_id;
          w_ptr_next      = w_ptr_after;
          w_state_next    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_tok_match) begin
          w_cnt_next        = 16'(HOLD_CYCLES - 1);
          w_fail_cnt_next   = 4'd0;
          w_lock_ovr_next   = r_kind;
          w_flush_ovr_next  = !r_kind;
          w_auth_valid_next = 1'b1;
          w_state_next      = S_ASSERT;
        end else begin
          w_auth_fail_next = 1'b1;
          w_fail_cnt_next  = w_fail_inc;
          if (w_fail_inc >= 4'(MAX_FAILS)) begin
            w_lockout_next = 1'b1;
          end
          w_cnt_next   = 16'(COOLDOWN_CYCLES - 1);
          w_state_next = S_COOLDOWN;
        end
      end
      S_ASSERT: begin
        if (r_cnt == 16'd0) begin
          w_lock_ovr_next   = 1'b0;
          w_flush_ovr_next  = 1'b0;
          w_auth_valid_next = 1'b0;
          w_cnt_next        = 16'(COOLDOWN_CYCLES - 1);
          w_state_next      = S_COOLDOWN;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_COOLDOWN: begin
        if (r_cnt == 16'd0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      default: begin
        w_lock_ovr_next   = 1'b0;
        w_flush_ovr_next  = 1'b0;
        w_auth_valid_next = 1'b0;
        w_state_next      = S_IDLE;
      end
    endcase

    // A key write never touches the hold in progress, but it does reset the
    // failure history and lift a lockout (overriding a same-cycle failure).
    if (key_wr_en) begin
      w_key_next        = key_wr_data;
      w_key_loaded_next = 1'b1;
      w_fail_cnt_next   = 4'd0;
      w_lockout_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_key        <= 16'd0;
      r_key_loaded <= 1'b0;
      r_fail_cnt   <= 4'd0;
      r_lockout    <= 1'b0;
      r_ptr        <= 3'd0;
      r_grant_id   <= 3'd0;
      r_kind       <= 1'b0;
      r_token      <= 16'd0;
      r_cnt        <= 16'd0;
      r_lock_ovr   <= 1'b0;
      r_flush_ovr  <= 1'b0;
      r_auth_valid <= 1'b0;
      r_auth_fail  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_key        <= w_key_next;
      r_key_loaded <= w_key_loaded_next;
      r_fail_cnt   <= w_fail_cnt_next;
      r_lockout    <= w_lockout_next;
      r_ptr        <= w_ptr_next;
      r_grant_id   <= w_grant_id_next;
      r_kind       <= w_kind_next;
      r_token      <= w_token_next;
      r_cnt        <= w_cnt_next;
      r_lock_ovr   <= w_lock_ovr_next;
      r_flush_ovr  <= w_flush_ovr_next;
      r_auth_valid <= w_auth_valid_next;
      r_auth_fail  <= w_auth_fail_next;
    end
  end

  assign analog_lock_override             = r_lock_ovr;
  assign analog_flush_override            = r_flush_ovr;
  assign override_authentication_valid_in = r_auth_valid;
  assign grant_id                         = r_grant_id;
  assign auth_fail                        = r_auth_fail;
  assign lockout                          = r_lockout;

  // --------------------------------------------------------------------------
  // Optional audit counters
  // --------------------------------------------------------------------------
`ifdef OVERRIDE_AUDIT_LOG_EN
  logic       w_pass;
  logic       w_fail;
  logic [7:0] r_audit_grant;
  logic [7:0] r_audit_fail;

  assign w_pass = (r_state == S_CHECK) && w_tok_match;
  assign w_fail = (r_state == S_CHECK) && !w_tok_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_audit_grant <= 8'd0;
      r_audit_fail  <= 8'd0;
    end else begin
      if (w_pass && (r_audit_grant != 8'hFF)) begin
        r_audit_grant <= r_audit_grant + 8'd1;
      end
      if (w_fail && (r_audit_fail != 8'hFF)) begin
        r_audit_fail <= r_audit_fail + 8'd1;
      end
    end
  end

  assign audit_grant_cnt = r_audit_grant;
  assign audit_fail_cnt  = r_audit_fail;
`else
  assign audit_grant_cnt = 8'd0;
  assign audit_fail_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_override_auth_arbiter.sv
// ----------------------------------------------------------------------------
// tb_override_auth_arbiter
//
// Directed stimulus for override_auth_arbiter with a cycle-indexed reference
// model: each accepted request schedules absolute cycle windows for its
// override, auth_fail pulse and return to idle. A compare process checks all
// outputs against that model every cycle; the main sequence also pins a set
// of hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_override_auth_arbiter;

  localparam int N     = 4;
  localparam int HOLD  = 16;
  localparam int COOL  = 4;
  localparam int MAXF  = 3;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_kind;
  logic [16*N-1:0]   req_token;
  logic [N-1:0]      req_ready;
  logic              key_wr_en;
  logic [15:0]       key_wr_data;
  logic              lock_ovr;
  logic              flush_ovr;
  logic              auth_valid;
  logic [2:0]        grant_id;
  logic              auth_fail;
  logic              lockout;
  logic [7:0]        audit_grant_cnt;
  logic [7:0]        audit_fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  override_auth_arbiter #(
    .N_REQ(N), .HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(COOL), .MAX_FAILS(MAXF)
  ) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .req_valid                        (req_valid),
    .req_kind                         (req_kind),
    .req_token                        (req_token),
    .req_ready                        (req_ready),
    .key_wr_en                        (key_wr_en),
    .key_wr_data                      (key_wr_data),
    .analog_lock_override             (lock_ovr),
    .analog_flush_override            (flush_ovr),
    .override_authentication_valid_in (auth_valid),
    .grant_id                         (grant_id),
    .auth_fail                        (auth_fail),
    .lockout                          (lockout),
    .audit_grant_cnt                  (audit_grant_cnt),
    .audit_fail_cnt                   (audit_fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model (absolute cycle windows)
  // --------------------------------------------------------------------------
  int          cyc = 0;
  bit          m_on = 1'b0;
  logic [15:0] m_key;
  bit          m_loaded;
  bit          m_lockout;
  int          m_fails;
  int          m_ptr;
  int          m_grant;
  int          m_check_at;
  int          m_fail_at;
  int          m_hold_s;
  int          m_hold_e;
  int          m_idle_at;
  bit          m_kind;
  logic [15:0] m_tok;
  int          m_ag;
  int          m_af;

  always @(negedge clk) begin
    int           wi;
    int           win;
    logic         any_lock;
    logic [N-1:0] exp_ready;
    logic         exp_lock;
    logic         exp_flush;
    logic         exp_av;
    int           exp_ag;
    int           exp_af;

    // Winner: lock class if any lock is valid, round-robin from m_ptr.
    any_lock  = |(req_valid & req_kind);
    win       = -1;
    exp_ready = '0;
    for (int k = 0; k < N; k++) begin
      wi = (m_ptr + k) % N;
      if (win < 0 && req_valid[wi] && (req_kind[wi] == any_lock)) win = wi;
    end
    if (m_on && cyc >= m_idle_at && m_loaded && !m_lockout && win >= 0) exp_ready[win] = 1'b1;

    exp_av    = (cyc >= m_hold_s) && (cyc <= m_hold_e);
    exp_lock  = exp_av && m_kind;
    exp_flush = exp_av && !m_kind;
`ifdef OVERRIDE_AUDIT_LOG_EN
    exp_ag = m_ag;
    exp_af = m_af;
`else
    exp_ag = 0;
    exp_af = 0;
`endif

    if (m_on) begin
      check("req_ready",  32'(req_ready),  32'(exp_ready));
      check("lock_ovr",   32'(lock_ovr),   32'(exp_lock));
      check("flush_ovr",  32'(flush_ovr),  32'(exp_flush));
      check("auth_valid", 32'(auth_valid), 32'(exp_av));
      check("auth_fail",  32'(auth_fail),  32'(cyc == m_fail_at));
      check("lockout",    32'(lockout),    32'(m_lockout));
      check("grant_id",   32'(grant_id),   32'(m_grant));
      check("audit_grant", 32'(audit_grant_cnt), 32'(exp_ag));
      check("audit_fail",  32'(audit_fail_cnt),  32'(exp_af));
    end

    // Advance the model across the coming clock edge.
    if (!rst_n) begin
      m_on = 1'b1; m_key = 16'd0; m_loaded = 1'b0; m_lockout = 1'b0;
      m_fails = 0; m_ptr = 0; m_grant = 0; m_check_at = -1; m_fail_at = -1;
      m_hold_s = -1; m_hold_e = -2; m_idle_at = cyc + 1; m_kind = 1'b0;
      m_tok = 16'd0; m_ag = 0; m_af = 0;
    end else if (m_on) begin
      if (cyc == m_check_at) begin
        if (m_tok == m_key) begin
          m_hold_s  = cyc + 1;
          m_hold_e  = cyc + HOLD;
          m_idle_at = cyc + 1 + HOLD + COOL;
          m_fails   = 0;
          if (m_ag < 255) m_ag++;
          $display("txn: check pass id=%0d kind=%0d token=%04h", m_grant, m_kind, m_tok);
        end else begin
          m_fail_at = cyc + 1;
          if (m_fails < MAXF) m_fails++;
          if (m_fails >= MAXF) m_lockout = 1'b1;
          m_idle_at = cyc + 1 + COOL;
          if (m_af < 255) m_af++;
          $display("txn: check reject id=%0d token=%04h key=%04h fails=%0d", m_grant, m_tok, m_key, m_fails);
        end
      end
      if (exp_ready != '0) begin
        m_grant    = win;
        m_ptr      = (win + 1) % N;
        m_kind     = req_kind[win];
        m_tok      = req_token[16*win +: 16];
        m_check_at = cyc + 1;
        m_idle_at  = cyc + 1000000;
        $display("txn: grant id=%0d kind=%0d token=%04h", win, m_kind, m_tok);
      end
      if (key_wr_en) begin
        m_key = key_wr_data; m_loaded = 1'b1; m_fails = 0; m_lockout = 1'b0;
        $display("txn: key write %04h", key_wr_data);
      end
    end
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_tok(input int i, input logic [15:0] v);
    req_token[16*i +: 16] = v;
  endtask

  task automatic key_write(input logic [15:0] v);
    key_wr_en   = 1'b1;
    key_wr_data = v;
    tick();
    key_wr_en   = 1'b0;
  endtask

  // Returns at the negedge of the accepting cycle.
  task automatic wait_ready(input logic [N-1:0] expv, input string nm);
    bit got = 1'b0;
    int n   = 0;
    while (!got && n < 200) begin
      sample();
      if (req_ready != '0) begin
        check(nm, 32'(req_ready), 32'(expv));
        got = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    if (!got) check({nm, "_timeout"}, 32'(req_ready), 32'(expv));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_kind = '0; req_token = '0;
    key_wr_en = 1'b0; key_wr_data = 16'd0;
    repeat (3) tick();
    sample();
    check("rst_lockout", 32'(lockout), 32'd0);
    check("rst_grant",   32'(grant_id), 32'd0);
    check("rst_av",      32'(auth_valid), 32'd0);
    tick();
    rst_n = 1'b1;

    // No key loaded: nothing is ever accepted.
    req_valid = 4'b0001; req_kind = 4'b0001;
    repeat (4) begin
      sample();
      check("nokey_ready", 32'(req_ready), 32'd0);
      check("nokey_lock",  32'(lock_ovr),  32'd0);
      tick();
    end
    req_valid = '0;

    // Lock request from requester 2 passes.
    key_write(16'hA5C3);
    set_tok(2, 16'hA5C3); req_valid = 4'b0100; req_kind = 4'b0100;
    sample(); check("t1_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    sample(); check("t1_check_av", 32'(auth_valid), 32'd0);
    tick();
    sample();
    check("t1_lock_first",  32'(lock_ovr),   32'd1);
    check("t1_av_first",    32'(auth_valid), 32'd1);
    check("t1_flush_first", 32'(flush_ovr),  32'd0);
    check("t1_grant",       32'(grant_id),   32'd2);
    repeat (15) tick();
    sample(); check("t1_lock_last", 32'(lock_ovr), 32'd1);
    tick();
    sample(); check("t1_lock_end", 32'(lock_ovr), 32'd0);
    repeat (3) tick();
    sample(); check("t1_cool_last", 32'(auth_valid), 32'd0);
    tick();

    // Mixed priority: lock 1 first, then flush 3 and 0 by round-robin.
    set_tok(0, 16'hA5C3); set_tok(1, 16'hA5C3); set_tok(3, 16'hA5C3);
    req_valid = 4'b1011; req_kind = 4'b0010;
    sample(); check("mix_ready1", 32'(req_ready), 32'h2);
    tick(); req_valid = 4'b1001; req_kind = 4'b0000;
    wait_ready(4'b1000, "mix_ready2");
    tick(); req_valid = 4'b0001;
    wait_ready(4'b0001, "mix_ready3");
    tick(); req_valid = '0;
    sample(); check("mix_grant0", 32'(grant_id), 32'd0);
    repeat (25) tick();

    // Three bad tokens reach lockout.
    set_tok(0, 16'h1234); req_valid = 4'b0001; req_kind = 4'b0000;
    for (int f = 0; f < 3; f++) begin
      wait_ready(4'b0001, "fail_ready");
      tick(); tick();
      sample();
      check("fail_pulse",   32'(auth_fail), 32'd1);
      check("fail_lockout", 32'(lockout),   32'(f == 2));
      tick();
    end
    repeat (30) begin
      sample();
      check("locked_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;

    // Key write clears lockout; matching token then passes.
    key_write(16'h0F0F);
    sample(); check("kw_lockout", 32'(lockout), 32'd0);
    tick();
    set_tok(3, 16'h0F0F); req_valid = 4'b1000; req_kind = 4'b1000;
    wait_ready(4'b1000, "kw_ready");
    tick(); req_valid = '0;
    tick();
    sample(); check("kw_lock", 32'(lock_ovr), 32'd1);

    // Reset at hold cycle 5 drops everything on the next edge.
    repeat (4) tick();
    rst_n = 1'b0;
    sample(); check("mid_lock_before", 32'(lock_ovr), 32'd1);
    tick();
    rst_n = 1'b1;
    sample();
    check("mid_lock_after",  32'(lock_ovr),   32'd0);
    check("mid_av_after",    32'(auth_valid), 32'd0);
    check("mid_grant_after", 32'(grant_id),   32'd0);
    tick();

    // Audit: pass, fail, pass.
    key_write(16'hBEEF);
    set_tok(0, 16'hBEEF); req_valid = 4'b0001; req_kind = 4'b0001;
    wait_ready(4'b0001, "aud_ready1");
    tick(); req_valid = '0;
    set_tok(0, 16'h1111); req_valid = 4'b0001;
    wait_ready(4'b0001, "aud_ready2");
    tick(); req_valid = '0;
    set_tok(0, 16'hBEEF); req_valid = 4'b0001;
    wait_ready(4'b0001, "aud_ready3");
    tick(); req_valid = '0;
    repeat (25) tick();
    sample();
`ifdef OVERRIDE_AUDIT_LOG_EN
    check("aud_grant_cnt", 32'(audit_grant_cnt), 32'd2);
    check("aud_fail_cnt",  32'(audit_fail_cnt),  32'd1);
`else
    check("aud_grant_cnt", 32'(audit_grant_cnt), 32'd0);
    check("aud_fail_cnt",  32'(audit_fail_cnt),  32'd0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
